line_window_buf: RTL and testbench

LINE_WINDOW_BUF -- requirements
Module: line_window_buf

---
 rtl/line_window_buf.sv | 144 ++++++++++++++
 tb/tb_line_window_buf.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_buf.sv
// line_window_buf: LN-line column window over a raster stream with a fixed 2-cycle latency.
// Define LINE_WINDOW_BORDER_REPLICATE_EN to fill unfilled rows with the oldest filled row instead of 0.
module line_window_buf #(
    parameter int unsigned DW = 8,
    parameter int unsigned IW = 1280,
    parameter int unsigned LN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic [DW-1:0]    i_data,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [LN*DW-1:0] o_data,
    output logic             o_valid,
    output logic             o_ovf
);

    localparam int unsigned CW = (IW > 1) ? $clog2(IW) : 1;
    localparam int unsigned LW = $clog2(LN);
    localparam logic [CW-1:0] COL_LAST  = CW'(IW - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LN - 1);

    logic [CW-1:0] r_col;
    logic          r_col_full;
    logic [LW-1:0] r_line;
    logic          r_de_d;
    logic          r_vs_d;

    logic [DW-1:0] r_s1_data;
    logic [CW-1:0] r_s1_addr;
    logic [LW-1:0] r_s1_line;
    logic          r_s1_de;
    logic          r_s1_hs;
    logic          r_s1_vs;
    logic          r_s1_we;
    logic          r_s1_ovf;

    logic          w_frame_start;
    logic          w_line_end;
    logic          w_col_last;
    logic [CW-1:0] w_col;
    logic          w_full;
    logic [LW-1:0] w_line;
    logic [DW-1:0] w_row [LN];
    logic [DW-1:0] w_border;
    logic [LN*DW-1:0] w_win;

    // Frame start overrides the running counters for the pixel arriving on the same cycle.
    assign w_frame_start = r_vs_d & ~i_vsync;
    assign w_line_end    = r_de_d & ~i_de;
    assign w_col         = w_frame_start ? '0 : r_col;
    assign w_full        = r_col_full & ~w_frame_start;
    assign w_line        = w_frame_start ? '0 : r_line;
    assign w_col_last    = (w_col == COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_col_full <= 1'b0;
            r_line     <= '0;
            r_de_d     <= 1'b0;
            r_vs_d     <= 1'b0;
            r_s1_data  <= '0;
            r_s1_addr  <= '0;
            r_s1_line  <= '0;
            r_s1_de    <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s1_we    <= 1'b0;
            r_s1_ovf   <= 1'b0;
        end else begin
            r_de_d  <= i_de;
            r_vs_d  <= i_vsync;
            r_s1_de <= i_de;
            r_s1_hs <= i_hsync;
            r_s1_vs <= i_vsync;
            r_s1_we <= i_de & ~w_full;
            r_s1_ovf <= i_de & w_full;
            if (i_de) begin
                r_col      <= w_col_last ? w_col : w_col + CW'(1);
                r_col_full <= w_full | w_col_last;
                r_s1_data  <= i_data;
                r_s1_addr  <= w_col;
                r_s1_line  <= w_line;
            end else if (w_line_end || w_frame_start) begin
                r_col      <= '0;
                r_col_full <= 1'b0;
            end
            if (w_frame_start) begin
                r_line <= '0;
            end else if (w_line_end && r_line != LINE_LAST) begin
                r_line <= r_line + LW'(1);
            end
        end
    end

    assign w_row[0] = r_s1_data;

    // Each store is read and rewritten at the same address; the old word feeds the next store down.
    for (genvar k = 1; k < LN; k++) begin : g_store
        logic [DW-1:0] r_mem [IW];
        always_ff @(posedge clk) begin
            if (!rst && r_s1_we) begin
                r_mem[r_s1_addr] <= w_row[k-1];
            end
        end
        assign w_row[k] = r_mem[r_s1_addr];
    end

`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
    assign w_border = w_row[r_s1_line];
`else
    assign w_border = '0;
`endif

    for (genvar i = 0; i < LN; i++) begin : g_win
        assign w_win[i*DW +: DW] = (LW'(i) <= r_s1_line) ? w_row[i] : w_border;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            o_hsync <= r_s1_hs;
            o_vsync <= r_s1_vs;
            o_de    <= r_s1_de;
            o_valid <= r_s1_de && (r_s1_line == LINE_LAST);
            o_ovf   <= r_s1_ovf;
            if (r_s1_de) begin
                o_data <= w_win;
            end
        end
    end

endmodule

// File: tb/tb_line_window_buf.sv
// Self-checking bench for line_window_buf (DW=8, IW=8, LN=3) against a per-column history model.
// Honours LINE_WINDOW_BORDER_REPLICATE_EN when the bench is built with it.
module tb_line_window_buf;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 8;
    localparam int unsigned LN = 3;
    localparam int unsigned OW = LN * DW;
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_hsync;
    logic          i_vsync;
    logic          i_de;
    logic [DW-1:0] i_data;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_de;
    logic [OW-1:0] o_data;
    logic          o_valid;
    logic          o_ovf;

    line_window_buf #(.DW(DW), .IW(IW), .LN(LN)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_hsync (i_hsync),
        .i_vsync (i_vsync),
        .i_de    (i_de),
        .i_data  (i_data),
        .o_hsync (o_hsync),
        .o_vsync (o_vsync),
        .o_de    (o_de),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          valid;
        logic          ovf;
        logic [OW-1:0] data;
    } out_t;

    // Model: per column, the pixels written there, newest first. Row i of the window is the
    // current pixel for i=0, otherwise the pixel written at this column i writes ago.
    logic [DW-1:0] hist [IW][$];
    int            m_pix;
    int            m_line;
    bit            m_prev_de;
    bit            m_prev_vs;
    bit            pp_v;
    int            pp_col;
    logic [DW-1:0] pp_val;
    logic [OW-1:0] m_last;
    out_t          pend;

    logic [DW-1:0] sent      [16];
    logic [OW-1:0] obs_data  [16];
    logic          obs_valid [16];
    logic          obs_ovf   [16];
    logic          obs_de    [16];
    logic          cur_vs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic out_t model_step(input logic rs, input logic hs, input logic vs,
                                        input logic de, input logic [DW-1:0] d);
        out_t          chk;
        out_t          nxt;
        logic [DW-1:0] rows [LN];
        int            addr;
        int            lsat;
        if (rs) begin
            chk       = '0;
            pend      = '0;
            m_last    = '0;
            pp_v      = 1'b0;
            m_pix     = 0;
            m_line    = 0;
            m_prev_de = 1'b0;
            m_prev_vs = 1'b0;
            return chk;
        end
        chk = pend;
        if (pp_v) begin
            hist[pp_col].push_front(pp_val);
            if (hist[pp_col].size() > LN - 1) void'(hist[pp_col].pop_back());
        end
        pp_v = 1'b0;
        if (m_prev_vs && !vs) begin
            m_pix  = 0;
            m_line = 0;
        end else if (m_prev_de && !de) begin
            m_pix  = 0;
            m_line = m_line + 1;
        end
        nxt    = '0;
        nxt.hs = hs;
        nxt.vs = vs;
        nxt.de = de;
        if (de) begin
            addr    = (m_pix < int'(IW)) ? m_pix : int'(IW) - 1;
            lsat    = (m_line < int'(LN) - 1) ? m_line : int'(LN) - 1;
            rows[0] = d;
            for (int i = 1; i < int'(LN); i++) rows[i] = hist[addr][i-1];
            for (int i = 0; i < int'(LN); i++) begin
                if (i <= lsat) m_last[i*DW +: DW] = rows[i];
                else m_last[i*DW +: DW] = REPL ? rows[lsat] : '0;
            end
            nxt.valid = (lsat == int'(LN) - 1);
            nxt.ovf   = (m_pix >= int'(IW));
            if (m_pix < int'(IW)) begin
                pp_v   = 1'b1;
                pp_col = addr;
                pp_val = d;
            end
            m_pix = m_pix + 1;
        end
        nxt.data  = m_last;
        pend      = nxt;
        m_prev_de = de;
        m_prev_vs = vs;
        return chk;
    endfunction

    task automatic step(input logic rs, input logic hs, input logic vs, input logic de,
                        input logic [DW-1:0] d);
        out_t exp;
        rst     = rs;
        i_hsync = hs;
        i_vsync = vs;
        i_de    = de;
        i_data  = d;
        exp = model_step(rs, hs, vs, de, d);
        @(posedge clk);
        #1;
        check("ctl", 64'({o_hsync, o_vsync, o_de}), 64'({exp.hs, exp.vs, exp.de}));
        check("data", 64'(o_data), 64'(exp.data));
        check("valid", 64'(o_valid), 64'(exp.valid));
        check("ovf", 64'(o_ovf), 64'(exp.ovf));
    endtask

    task automatic capture(input int k);
        obs_data[k]  = o_data;
        obs_valid[k] = o_valid;
        obs_ovf[k]   = o_ovf;
        obs_de[k]    = o_de;
    endtask

    task automatic frame_start();
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        cur_vs = 1'b0;
    endtask

    // Output for pixel j is captured after the step of pixel j+1 (or the first trailing blank).
    task automatic send_line(input int n, input bit rnd, input logic [DW-1:0] base,
                             input bit vs_on_pix0, input int rst_at);
        logic [DW-1:0] d;
        int            lead;
        lead = vs_on_pix0 ? 1 : 2;
        for (int j = 0; j < lead; j++) step(1'b0, 1'b1, cur_vs, 1'b0, '0);
        for (int j = 0; j < n; j++) begin
            d = rnd ? DW'($urandom) : base + DW'(j);
            if (j == 0 && vs_on_pix0) cur_vs = 1'b0;
            sent[j] = d;
            step(logic'(j == rst_at), 1'b0, cur_vs, 1'b1, d);
            if (j > 0) capture(j - 1);
        end
        step(1'b0, 1'b0, cur_vs, 1'b0, '0);
        capture(n - 1);
        step(1'b0, 1'b0, cur_vs, 1'b0, '0);
    endtask

    initial begin
        logic [DW-1:0]   prev0;
        logic [2*DW-1:0] upper;
        int              nl;
        cur_vs  = 1'b0;
        rst     = 1'b1;
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        i_de    = 1'b0;
        i_data  = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);
        check("reset_outputs", 64'({o_hsync, o_vsync, o_de, o_valid, o_ovf, o_data}), 64'(0));
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Fill every column of both stores so later reads are defined.
        frame_start();
        send_line(8, 1'b1, '0, 1'b0, -1);
        send_line(8, 1'b1, '0, 1'b0, -1);

        frame_start();
        send_line(4, 1'b0, 8'h10, 1'b0, -1);
        check("first_line_px0_data", 64'(obs_data[0]), REPL ? 64'h101010 : 64'h000010);
        check("first_line_px0_valid", 64'(obs_valid[0]), 64'(0));
        send_line(4, 1'b0, 8'h20, 1'b0, -1);
        check("second_line_valid", 64'(obs_valid[2]), 64'(0));
        send_line(4, 1'b0, 8'h30, 1'b0, -1);
        check("line3_col1_data", 64'(obs_data[1]), 64'h112131);
        check("line3_col1_valid", 64'(obs_valid[1]), 64'(1));

        send_line(10, 1'b1, '0, 1'b0, -1);
        for (int j = 0; j < 10; j++) check("ovf_pulse", 64'(obs_ovf[j]), 64'(j >= 8));
        check("ovf_px9_row0", 64'(obs_data[9][DW-1:0]), 64'(sent[9]));
        prev0 = sent[0];
        send_line(4, 1'b1, '0, 1'b0, -1);
        check("after_ovf_col0_row1", 64'(obs_data[0][DW +: DW]), 64'(prev0));

        frame_start();
        for (int l = 0; l < 3; l++) begin
            send_line(5, 1'b1, '0, 1'b0, -1);
            check("new_frame_valid", 64'(obs_valid[0]), 64'(l == 2));
        end

        cur_vs = 1'b1;
        send_line(4, 1'b1, '0, 1'b1, -1);
        upper = REPL ? {sent[0], sent[0]} : '0;
        check("vs_de_coincide_valid", 64'(obs_valid[0]), 64'(0));
        check("vs_de_coincide_rows", 64'(obs_data[0][OW-1:DW]), 64'(upper));

        send_line(4, 1'b1, '0, 1'b0, -1);
        send_line(6, 1'b1, '0, 1'b0, 2);
        check("rst_pulse_de", 64'(obs_de[1]), 64'(0));
        check("rst_pulse_data", 64'(obs_data[1]), 64'(0));
        check("post_rst_px_valid", 64'(obs_valid[3]), 64'(0));
        check("post_rst_px_data", 64'(obs_data[3]),
              REPL ? 64'({sent[3], sent[3], sent[3]}) : 64'(sent[3]));
        send_line(4, 1'b1, '0, 1'b0, -1);
        check("post_rst_next_line_valid", 64'(obs_valid[0]), 64'(0));

        for (int f = 0; f < 4; f++) begin
            frame_start();
            nl = int'($urandom_range(3, 5));
            for (int l = 0; l < nl; l++) begin
                send_line(int'($urandom_range(1, 10)), 1'b1, '0, 1'b0,
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1);
                for (int b = 0; b < int'($urandom_range(0, 2)); b++)
                    step(1'b0, 1'b0, cur_vs, 1'b0, '0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
